// File: rtl/fp_round_unit_if.sv
// Operand/result bundle between the FP arithmetic units, the rounding stage and writeback.
// The master drives operands and samples results; the slave is the rounding stage.
interface fp_round_unit_if;
    logic        valid_i;
    logic [31:0] to_round_i;
    logic [2:0]  grs_i;
    logic [2:0]  round_mode_i;
    logic        overflow_i;
    logic        underflow_i;
    logic        invalid_op_i;
    logic [31:0] result_o;
    logic [4:0]  flags_o;
    logic        valid_o;
    logic        fu_state_o;

    modport master (
        output valid_i, to_round_i, grs_i, round_mode_i, overflow_i, underflow_i, invalid_op_i,
        input  result_o, flags_o, valid_o, fu_state_o
    );

    modport slave (
        input  valid_i, to_round_i, grs_i, round_mode_i, overflow_i, underflow_i, invalid_op_i,
        output result_o, flags_o, valid_o, fu_state_o
    );
endinterface

// File: rtl/fp_round_unit.sv
// Multi-cycle binary32 rounding stage: applies the RISC-V rounding mode, resolves
// carry/overflow and special values, and produces the final result with fflags.
module fp_round_unit #(
    parameter logic [31:0] CANO_NAN_VAL = 32'h7FC00000,
    parameter logic [30:0] MAX_FINITE   = 31'h7F7FFFFF
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clk_en_i,
    fp_round_unit_if.slave  bus
);
    localparam int unsigned EXP_W = 8;
    localparam int unsigned MAG_W = 31;

    localparam logic [2:0] RNE = 3'd0;
    localparam logic [2:0] RTZ = 3'd1;
    localparam logic [2:0] RDN = 3'd2;
    localparam logic [2:0] RUP = 3'd3;
    localparam logic [2:0] RMM = 3'd4;

    localparam logic [EXP_W-1:0] EXP_MAX = 8'hFF;
    localparam logic [31:0]      POS_INF = 32'h7F800000;

    typedef enum logic [1:0] {IDLE, ROUND, FIXUP, VALID} state_e;

    state_e           state_q, state_d;
    logic             sign_q;
    logic [MAG_W-1:0] mag_q;
    logic [2:0]       grs_q;
    logic [2:0]       mode_q;
    logic             of_q, uf_q, nv_q;
    logic [MAG_W-1:0] sum_q, sum_d;
    logic             nx_q, nx_d;
    logic [31:0]      result_q, result_d;
    logic [4:0]       flags_q, flags_d;

    logic             inc;
    logic             illegal_mode;
    logic [EXP_W-1:0] in_exp, sum_exp;
    logic [31:0]      ovf_res;

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (bus.valid_i) state_d = ROUND;
            ROUND:   state_d = FIXUP;
            FIXUP:   state_d = VALID;
            VALID:   state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // ROUND: increment decision and 31-bit add; mantissa carry ripples into the exponent
    always_comb begin
        inc = 1'b0;
        case (mode_q)
            RNE:     inc = grs_q[2] & (grs_q[1] | grs_q[0] | mag_q[0]);
            RTZ:     inc = 1'b0;
            RDN:     inc = sign_q & (|grs_q);
            RUP:     inc = ~sign_q & (|grs_q);
            RMM:     inc = grs_q[2];
            default: inc = 1'b0;
        endcase
        sum_d = mag_q + MAG_W'(inc);
        nx_d  = |grs_q;
    end

    // FIXUP: special values and overflow take priority over the rounded sum
    always_comb begin
        illegal_mode = (mode_q > RMM);
        in_exp       = mag_q[30:23];
        sum_exp      = sum_q[30:23];

        ovf_res = {sign_q, POS_INF[30:0]};
        case (mode_q)
            RTZ:     ovf_res = {sign_q, MAX_FINITE};
            RDN:     ovf_res = sign_q ? {1'b1, POS_INF[30:0]} : {1'b0, MAX_FINITE};
            RUP:     ovf_res = sign_q ? {1'b1, MAX_FINITE} : POS_INF;
            default: ovf_res = {sign_q, POS_INF[30:0]};
        endcase

        result_d = {sign_q, sum_q};
        flags_d  = {3'b000, uf_q | ((sum_exp == '0) & nx_q), nx_q};
        if (nv_q || illegal_mode) begin
            result_d = CANO_NAN_VAL;
            flags_d  = 5'b10000;
        end else if ((in_exp == EXP_MAX) && (mag_q[22:0] != '0)) begin
            result_d = CANO_NAN_VAL;
            flags_d  = 5'b00000;
        end else if (in_exp == EXP_MAX) begin
            result_d = {sign_q, mag_q};
            flags_d  = {2'b00, of_q, 2'b00};
        end else if ((sum_exp == EXP_MAX) || of_q) begin
            result_d = ovf_res;
            flags_d  = 5'b00101;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= IDLE;
            sign_q   <= 1'b0;
            mag_q    <= '0;
            grs_q    <= '0;
            mode_q   <= '0;
            of_q     <= 1'b0;
            uf_q     <= 1'b0;
            nv_q     <= 1'b0;
            sum_q    <= '0;
            nx_q     <= 1'b0;
            result_q <= '0;
            flags_q  <= '0;
        end else if (clk_en_i) begin
            state_q <= state_d;
            if (state_q == IDLE && bus.valid_i) begin
                sign_q <= bus.to_round_i[31];
                mag_q  <= bus.to_round_i[30:0];
                grs_q  <= bus.grs_i;
                mode_q <= bus.round_mode_i;
                of_q   <= bus.overflow_i;
                uf_q   <= bus.underflow_i;
                nv_q   <= bus.invalid_op_i;
            end
            if (state_q == ROUND) begin
                sum_q <= sum_d;
                nx_q  <= nx_d;
            end
            if (state_q == FIXUP) begin
                result_q <= result_d;
                flags_q  <= flags_d;
            end
        end
    end

    assign bus.result_o   = result_q;
    assign bus.flags_o    = flags_q;
    assign bus.valid_o    = (state_q == VALID) & clk_en_i;
    assign bus.fu_state_o = (state_q != IDLE);
endmodule

// File: tb/tb_fp_round_unit.sv
// Scoreboard bench for fp_round_unit: expected result/flags/arrival cycle queued at
// drive time, compared when valid_o is seen.
module tb_fp_round_unit;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic clk_en = 1'b1;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_fail = 0;

    fp_round_unit_if bus();

    fp_round_unit dut (
        .clk_i   (clk),
        .rst_i   (rst),
        .clk_en_i(clk_en),
        .bus     (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  flg;
        int          cyc;
    } exp_t;

    typedef struct {
        logic [31:0] x;
        logic [2:0]  grs;
        logic [2:0]  mode;
        logic        of;
        logic        uf;
        logic        nv;
        logic [31:0] res;
        logic [4:0]  flg;
    } vec_t;

    exp_t sb_q[$];

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Monitor: every valid_o pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (bus.valid_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check_eq("spurious_valid", 32'(bus.valid_o), 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_eq("result", bus.result_o, e.res);
                check_eq("flags", 32'(bus.flags_o), 32'(e.flg));
                check_eq("arrival_cycle", 32'(cyc), 32'(e.cyc));
            end
        end
    end

    task automatic set_inputs(input vec_t v);
        bus.to_round_i   = v.x;
        bus.grs_i        = v.grs;
        bus.round_mode_i = v.mode;
        bus.overflow_i   = v.of;
        bus.underflow_i  = v.uf;
        bus.invalid_op_i = v.nv;
    endtask

    // One operation: accepted on the next rising edge; result lands two edges later (+stall)
    task automatic drive(input vec_t v, input int extra, input bit push);
        exp_t e;
        @(negedge clk);
        set_inputs(v);
        bus.valid_i = 1'b1;
        e.res = v.res;
        e.flg = v.flg;
        e.cyc = cyc + 3 + extra;
        if (push) sb_q.push_back(e);
        @(negedge clk);
        bus.valid_i = 1'b0;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 64; i++) begin
            if (sb_q.size() == 0 && bus.fu_state_o === 1'b0) break;
            @(negedge clk);
        end
        check_eq("drain", 32'(sb_q.size()), 32'd0);
    endtask

    vec_t vecs[$];

    initial begin
        vec_t v;
        bus.valid_i = 1'b0;
        set_inputs('{default: '0});

        vecs.push_back('{32'h3F800000, 3'b100, 3'd0, 1'b0, 1'b0, 1'b0, 32'h3F800000, 5'b00001});
        vecs.push_back('{32'h3F800001, 3'b100, 3'd0, 1'b0, 1'b0, 1'b0, 32'h3F800002, 5'b00001});
        vecs.push_back('{32'h3FFFFFFF, 3'b110, 3'd0, 1'b0, 1'b0, 1'b0, 32'h40000000, 5'b00001});
        vecs.push_back('{32'h3FFFFFFF, 3'b110, 3'd1, 1'b0, 1'b0, 1'b0, 32'h3FFFFFFF, 5'b00001});
        vecs.push_back('{32'h7F7FFFFF, 3'b100, 3'd0, 1'b0, 1'b0, 1'b0, 32'h7F800000, 5'b00101});
        vecs.push_back('{32'hFF7FFFFF, 3'b001, 3'd2, 1'b0, 1'b0, 1'b0, 32'hFF800000, 5'b00101});
        vecs.push_back('{32'hFF7FFFFF, 3'b001, 3'd3, 1'b0, 1'b0, 1'b0, 32'hFF7FFFFF, 5'b00001});
        vecs.push_back('{32'h7F800001, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 32'h7FC00000, 5'b00000});
        vecs.push_back('{32'h3F800000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b1, 32'h7FC00000, 5'b10000});
        vecs.push_back('{32'h3F800000, 3'b000, 3'd5, 1'b0, 1'b0, 1'b0, 32'h7FC00000, 5'b10000});
        vecs.push_back('{32'hFF800000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 32'hFF800000, 5'b00000});
        vecs.push_back('{32'h80000000, 3'b000, 3'd0, 1'b0, 1'b0, 1'b0, 32'h80000000, 5'b00000});
        vecs.push_back('{32'h00000001, 3'b100, 3'd0, 1'b0, 1'b0, 1'b0, 32'h00000002, 5'b00011});
        vecs.push_back('{32'h3F800000, 3'b100, 3'd4, 1'b0, 1'b0, 1'b0, 32'h3F800001, 5'b00001});
        vecs.push_back('{32'h3F800000, 3'b000, 3'd1, 1'b1, 1'b0, 1'b0, 32'h7F7FFFFF, 5'b00101});
        vecs.push_back('{32'h7F800000, 3'b000, 3'd0, 1'b1, 1'b0, 1'b0, 32'h7F800000, 5'b00100});
        vecs.push_back('{32'hBF800000, 3'b010, 3'd3, 1'b0, 1'b0, 1'b0, 32'hBF800000, 5'b00001});
        vecs.push_back('{32'h3F800000, 3'b010, 3'd3, 1'b0, 1'b0, 1'b0, 32'h3F800001, 5'b00001});

        // Reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_eq("rst_result", bus.result_o, 32'h0);
        check_eq("rst_flags", 32'(bus.flags_o), 32'h0);
        check_eq("rst_valid", 32'(bus.valid_o), 32'h0);
        check_eq("rst_fu_state", 32'(bus.fu_state_o), 32'h0);

        // Cycle-by-cycle handshake on the first operation
        drive(vecs[0], 0, 1'b1);
        check_eq("round_fu", 32'(bus.fu_state_o), 32'd1);
        check_eq("round_valid", 32'(bus.valid_o), 32'd0);
        @(negedge clk);
        check_eq("fixup_fu", 32'(bus.fu_state_o), 32'd1);
        check_eq("fixup_valid", 32'(bus.valid_o), 32'd0);
        @(negedge clk);
        check_eq("valid_fu", 32'(bus.fu_state_o), 32'd1);
        check_eq("valid_valid", 32'(bus.valid_o), 32'd1);
        @(negedge clk);
        check_eq("idle_fu", 32'(bus.fu_state_o), 32'd0);
        check_eq("idle_valid", 32'(bus.valid_o), 32'd0);
        wait_done();

        // Directed value table
        for (int i = 1; i < vecs.size(); i++) begin
            drive(vecs[i], 0, 1'b1);
            wait_done();
        end

        // valid_i held high: a new accept every four cycles
        begin
            exp_t e;
            @(negedge clk);
            set_inputs(vecs[2]);
            bus.valid_i = 1'b1;
            e.res = vecs[2].res;
            e.flg = vecs[2].flg;
            e.cyc = cyc + 3;
            sb_q.push_back(e);
            e.cyc = cyc + 7;
            sb_q.push_back(e);
            repeat (5) @(negedge clk);
            bus.valid_i = 1'b0;
            wait_done();
        end

        // Clock enable low for two cycles while in ROUND
        drive(vecs[1], 2, 1'b1);
        clk_en = 1'b0;
        repeat (2) @(negedge clk);
        check_eq("stall_fu", 32'(bus.fu_state_o), 32'd1);
        clk_en = 1'b1;
        wait_done();

        // Reset during FIXUP aborts the operation
        drive(vecs[4], 0, 1'b0);
        @(negedge clk);
        check_eq("abort_fu_pre", 32'(bus.fu_state_o), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check_eq("abort_result", bus.result_o, 32'h0);
        check_eq("abort_flags", 32'(bus.flags_o), 32'h0);
        check_eq("abort_fu", 32'(bus.fu_state_o), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check_eq("abort_valid", 32'(bus.valid_o), 32'd0);
            @(negedge clk);
        end

        // Unit still works after the abort
        drive(vecs[13], 0, 1'b1);
        wait_done();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded time limit at cycle %0d", cyc);
        $fatal(1, "timeout");
    end
endmodule
